turret_apb_servo: RTL and testbench
===================================

// Module: turret_apb_servo
// PURPOSE
//  APB3 completer in the FPGA fabric, answering the MSS fabric APB master (MSSP* bus).
//  Holds the turret control registers: pan/tilt servo pulse widths, PWM enable and a
//  fire trigger. Generates two glitch-free servo PWM outputs and a timed FIRE_OUT pulse.
//  Sits between the MSS top level and the turret pins.
// PARAMETERS
//  PERIOD_CYCLES  2000000   servo frame length in FAB_CLK cycles (20 ms @ 100 MHz)
//  PW_MIN         100000    minimum pulse width, cycles (1 ms)
//  PW_MAX         200000    maximum pulse width, cycles (2 ms)
//  PW_RESET       150000    pulse width after reset (centre)
//  FIRE_CYCLES    10000000  FIRE_OUT high time, cycles (100 ms)
// PORTS
//  FAB_CLK      in   1   fabric clock; all logic on rising edge
//  M2F_RESET_N  in   1   asynchronous active-low reset
//  PSEL         in   1   APB select (from MSSPSEL)
//  PENABLE      in   1   APB enable
//  PWRITE       in   1   1=write, 0=read
//  PADDR        in   8   byte address; only [7:2] decoded
//  PWDATA       in   32  write data
//  PRDATA       out  32  read data
//  PREADY       out  1   transfer complete
//  PSLVERR      out  1   transfer error (unmapped address)
//  PAN_PWM      out  1   pan servo PWM
//  TILT_PWM     out  1   tilt servo PWM
//  FIRE_OUT     out  1   trigger solenoid drive
// BEHAVIOUR
//  Register map (word offsets):
//   0x00 CTRL    [0] EN r/w; [1] FIRE write-1 trigger, reads 0
//   0x04 PAN_PW  [20:0] r/w shadow width; 0x08 TILT_PW [20:0] r/w shadow width
//   0x0C STATUS  [0] FIRE_BUSY ro; [1] FRAME_FLAG, write 1 to clear
//  Reset: CTRL.EN=0, shadows=PW_RESET, FRAME_FLAG=0, PRDATA=0, PREADY=1, PSLVERR=0,
//   PAN_PWM=TILT_PWM=FIRE_OUT=0, frame counter=0, fire counter=0.
//  APB: setup = PSEL&!PENABLE; access = PSEL&PENABLE.
//   Write: zero wait; PREADY=1 in first access cycle; register updates on that edge.
//   Read: one wait state; first access cycle PREADY=0 and PRDATA registered;
//    second access cycle PREADY=1, PRDATA valid. PREADY=1 whenever not in read wait.
//   PSLVERR=1 only in the access cycle where PREADY=1 and PADDR[7:2]>3; unmapped
//    writes change nothing, unmapped reads return 0. Bits outside fields read 0.
//   Unused bits of writes ignored. Reserved bits never stored.
//  Clamp: PW writes <PW_MIN store PW_MIN, >PW_MAX store PW_MAX (compare full 32 bits).
//  Frame counter: EN=0 -> held at 0, PWM outputs 0, active widths track shadows each
//   cycle. EN=1 -> counts 0..PERIOD_CYCLES-1 and wraps; PWM output = (cnt < active_pw),
//   registered (1 cycle latency). Active widths load from shadows only on the edge
//   where cnt wraps to 0, so a mid-frame write never shortens/extends current pulse.
//   FRAME_FLAG sets on each wrap; a W1C in the same cycle as a wrap leaves it set.
//  EN 1->0 mid-frame: counter and outputs go to 0 next cycle. EN 0->1: frame starts cnt=0.
//  Fire: write CTRL[1]=1 with FIRE_BUSY=0 -> FIRE_OUT=1 from next cycle for exactly
//   FIRE_CYCLES cycles, then 0; FIRE_BUSY=FIRE_OUT. Trigger while busy is ignored
//   (no retrigger/extension). Fire works regardless of EN. Same write may set EN.
//  Reset assertion at any time (mid-transfer, mid-pulse) returns all state to reset values
//   immediately; no transfer is completed.
// TESTING (bench uses PERIOD_CYCLES=1000, PW_MIN=50, PW_MAX=100, PW_RESET=75, FIRE_CYCLES=20)
//  Reset, read 0x04/0x08/0x00 -> 75, 75, 0; each read PREADY low 1 cycle; PSLVERR=0.
//  Write PAN_PW=10 then 500, read back -> 50 then 100; write TILT_PW=60 -> reads 60.
//  EN=1, PAN_PW=80 -> PAN_PWM high 80 cycles per 1000-cycle frame; write 60 at cnt=30
//   -> current pulse still 80, next frame 60; FRAME_FLAG=1, W1C clears it.
//  Write CTRL=0x2 -> FIRE_OUT high exactly 20 cycles; second trigger at cycle 10 ignored;
//   STATUS[0] reads 1 during pulse, 0 after.
//  Read/write 0x10 -> PSLVERR=1 with PREADY=1, read data 0, no register changes.
//  Assert M2F_RESET_N low mid-read wait and mid-pulse -> all outputs reset values at once.

Source files
------------

// File: rtl/turret_apb_servo.sv
// turret_apb_servo: APB3 completer holding the turret control registers.
// It drives two servo PWM outputs, which only change width at a frame
// boundary, and a fixed-length FIRE_OUT pulse for the trigger solenoid.
// Writes complete with zero wait states. Reads insert one wait state so
// that PRDATA comes from a register.
module turret_apb_servo #(
    parameter int PERIOD_CYCLES = 2000000,
    parameter int PW_MIN        = 100000,
    parameter int PW_MAX        = 200000,
    parameter int PW_RESET      = 150000,
    parameter int FIRE_CYCLES   = 10000000
) (
    input  logic        FAB_CLK,
    input  logic        M2F_RESET_N,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [7:0]  PADDR,
    input  logic [31:0] PWDATA,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic        PSLVERR,
    output logic        PAN_PWM,
    output logic        TILT_PWM,
    output logic        FIRE_OUT
);

    localparam int PW_W   = 21;
    localparam int CNT_W  = (PERIOD_CYCLES > 1) ? $clog2(PERIOD_CYCLES) : 1;
    localparam int FIRE_W = $clog2(FIRE_CYCLES + 1);

    localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(PERIOD_CYCLES - 1);
    localparam logic [PW_W-1:0]   PW_MIN_V   = PW_W'(PW_MIN);
    localparam logic [PW_W-1:0]   PW_MAX_V   = PW_W'(PW_MAX);
    localparam logic [PW_W-1:0]   PW_RESET_V = PW_W'(PW_RESET);
    localparam logic [FIRE_W-1:0] FIRE_LOAD  = FIRE_W'(FIRE_CYCLES);

    // Register state
    logic              en_q, en_d;
    logic [PW_W-1:0]   pan_sh_q, pan_sh_d, tilt_sh_q, tilt_sh_d;
    logic [PW_W-1:0]   pan_act_q, pan_act_d, tilt_act_q, tilt_act_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              pan_pwm_q, pan_pwm_d, tilt_pwm_q, tilt_pwm_d;
    logic              flag_q, flag_d;
    logic              fire_q, fire_d;
    logic [FIRE_W-1:0] fire_cnt_q, fire_cnt_d;
    logic [31:0]       prdata_q, prdata_d;
    logic              pready_q, pready_d;
    logic              pslverr_q, pslverr_d;

    // Bus decode
    logic [5:0]  word;
    logic        unmapped, setup, access, wr_en, rd_cap;
    logic        fire_trig, flag_w1c, run, wrap;
    logic [31:0] rdata;
    logic        unused_addr_bits;

    assign word     = PADDR[7:2];
    assign unmapped = (word > 6'd3);
    assign setup    = PSEL & ~PENABLE;
    assign access   = PSEL & PENABLE;
    // A write is accepted in its first access cycle. A read's data is captured
    // in its first access cycle, which is the wait state.
    assign wr_en    = access & PWRITE & pready_q;
    assign rd_cap   = access & ~PWRITE & ~pready_q;
    assign unused_addr_bits = ^PADDR[1:0];

    assign fire_trig = wr_en & (word == 6'd0) & PWDATA[1] & ~fire_q;
    assign flag_w1c  = wr_en & (word == 6'd3) & PWDATA[1];
    // The frame runs only while EN is set now and stays set after this edge.
    // Clearing EN therefore zeroes the counter and the outputs on the edge
    // of the write itself.
    assign run  = en_q & en_d;
    assign wrap = run & (cnt_q == CNT_LAST);

    // Saturate the full 32-bit write value into the legal pulse-width window
    function automatic logic [PW_W-1:0] clamp_pw(input logic [31:0] v);
        logic [PW_W-1:0] r;
        if (v < 32'(PW_MIN)) begin
            r = PW_MIN_V;
        end else if (v > 32'(PW_MAX)) begin
            r = PW_MAX_V;
        end else begin
            r = v[PW_W-1:0];
        end
        return r;
    endfunction

    // Read-data multiplexer; unmapped words and fields outside the map read 0
    always_comb begin
        rdata = 32'd0;
        case (word)
            6'd0:    rdata = {31'd0, en_q};
            6'd1:    rdata = {{(32-PW_W){1'b0}}, pan_sh_q};
            6'd2:    rdata = {{(32-PW_W){1'b0}}, tilt_sh_q};
            6'd3:    rdata = {30'd0, flag_q, fire_q};
            default: rdata = 32'd0;
        endcase
    end

    // Register writes: EN and the clamped pulse-width shadows
    always_comb begin
        en_d      = en_q;
        pan_sh_d  = pan_sh_q;
        tilt_sh_d = tilt_sh_q;
        if (wr_en) begin
            case (word)
                6'd0:    en_d      = PWDATA[0];
                6'd1:    pan_sh_d  = clamp_pw(PWDATA);
                6'd2:    tilt_sh_d = clamp_pw(PWDATA);
                default: ;
            endcase
        end
    end

    // Frame counter, active widths, PWM compare and frame flag
    always_comb begin
        cnt_d      = cnt_q;
        pan_act_d  = pan_act_q;
        tilt_act_d = tilt_act_q;
        pan_pwm_d  = 1'b0;
        tilt_pwm_d = 1'b0;
        if (!run) begin
            // While idle the active widths follow the shadows, so a new frame
            // starts with the latest values.
            cnt_d      = '0;
            pan_act_d  = pan_sh_q;
            tilt_act_d = tilt_sh_q;
        end else begin
            cnt_d      = wrap ? '0 : cnt_q + 1'b1;
            pan_pwm_d  = (32'(cnt_q) < 32'(pan_act_q));
            tilt_pwm_d = (32'(cnt_q) < 32'(tilt_act_q));
            if (wrap) begin
                pan_act_d  = pan_sh_q;
                tilt_act_d = tilt_sh_q;
            end
        end
        // If a wrap and a clear land on the same edge, the wrap wins.
        flag_d = flag_q;
        if (flag_w1c) begin
            flag_d = 1'b0;
        end
        if (wrap) begin
            flag_d = 1'b1;
        end
    end

    // Fire one-shot: load the counter on a trigger and drop FIRE_OUT on the last count
    always_comb begin
        fire_d     = fire_q;
        fire_cnt_d = fire_cnt_q;
        if (fire_trig) begin
            fire_d     = 1'b1;
            fire_cnt_d = FIRE_LOAD;
        end else if (fire_cnt_q != '0) begin
            fire_cnt_d = fire_cnt_q - 1'b1;
            fire_d     = (fire_cnt_q > FIRE_W'(1));
        end
    end

    // APB response: a read setup drops PREADY for the wait state; PSLVERR is
    // raised for the cycle in which PREADY is high
    always_comb begin
        pready_d  = ~(setup & ~PWRITE);
        pslverr_d = unmapped & ((setup & PWRITE) | rd_cap);
        prdata_d  = rd_cap ? rdata : prdata_q;
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge FAB_CLK or negedge M2F_RESET_N) begin
        if (!M2F_RESET_N) begin
            en_q       <= 1'b0;
            pan_sh_q   <= PW_RESET_V;
            tilt_sh_q  <= PW_RESET_V;
            pan_act_q  <= PW_RESET_V;
            tilt_act_q <= PW_RESET_V;
            cnt_q      <= '0;
            pan_pwm_q  <= 1'b0;
            tilt_pwm_q <= 1'b0;
            flag_q     <= 1'b0;
            fire_q     <= 1'b0;
            fire_cnt_q <= '0;
            prdata_q   <= 32'd0;
            pready_q   <= 1'b1;
            pslverr_q  <= 1'b0;
        end else begin
            en_q       <= en_d;
            pan_sh_q   <= pan_sh_d;
            tilt_sh_q  <= tilt_sh_d;
            pan_act_q  <= pan_act_d;
            tilt_act_q <= tilt_act_d;
            cnt_q      <= cnt_d;
            pan_pwm_q  <= pan_pwm_d;
            tilt_pwm_q <= tilt_pwm_d;
            flag_q     <= flag_d;
            fire_q     <= fire_d;
            fire_cnt_q <= fire_cnt_d;
            prdata_q   <= prdata_d;
            pready_q   <= pready_d;
            pslverr_q  <= pslverr_d;
        end
    end

    assign PRDATA   = prdata_q;
    assign PREADY   = pready_q;
    assign PSLVERR  = pslverr_q;
    assign PAN_PWM  = pan_pwm_q;
    assign TILT_PWM = tilt_pwm_q;
    assign FIRE_OUT = fire_q;

endmodule

// File: tb/tb_turret_apb_servo.sv
// Scoreboard bench for turret_apb_servo. The APB driver queues the expected
// completion of each transfer; monitors compare APB completions, PAN_PWM
// pulse widths and FIRE_OUT pulse lengths against those queues.
module tb_turret_apb_servo;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        psel, penable, pwrite;
    logic [7:0]  paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready, pslverr, pan_pwm, tilt_pwm, fire_out;

    always #5 clk = ~clk;

    turret_apb_servo #(
        .PERIOD_CYCLES(1000),
        .PW_MIN       (50),
        .PW_MAX       (100),
        .PW_RESET     (75),
        .FIRE_CYCLES  (20)
    ) dut (
        .FAB_CLK    (clk),
        .M2F_RESET_N(rst_n),
        .PSEL       (psel),
        .PENABLE    (penable),
        .PWRITE     (pwrite),
        .PADDR      (paddr),
        .PWDATA     (pwdata),
        .PRDATA     (prdata),
        .PREADY     (pready),
        .PSLVERR    (pslverr),
        .PAN_PWM    (pan_pwm),
        .TILT_PWM   (tilt_pwm),
        .FIRE_OUT   (fire_out)
    );

    typedef struct {
        string       name;
        logic        is_read;
        logic [31:0] rdata;
        logic        err;
        int          waits;
    } apb_exp_t;

    apb_exp_t apb_q[$];
    int       pan_q[$];
    int       fire_q[$];
    int       n_checks = 0;
    int       n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic apb(input string name, input logic wr, input logic [7:0] addr,
                       input logic [31:0] data, input logic [31:0] exp_rd, input logic exp_err);
        apb_exp_t e;
        logic     got;
        e.name    = name;
        e.is_read = ~wr;
        e.rdata   = exp_rd;
        e.err     = exp_err;
        e.waits   = wr ? 0 : 1;
        apb_q.push_back(e);
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = data;
        @(posedge clk); #1;
        penable = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (pready) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) check({name, " PREADY timeout"}, 32'd0, 32'd1);
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
        $display("apb %s addr=0x%02h wdata=0x%08h prdata=0x%08h pslverr=%0d",
                 wr ? "WR" : "RD", addr, data, prdata, pslverr);
    endtask

    // APB completion monitor
    int       mon_waits = 0;
    apb_exp_t mon_e;
    always @(negedge clk) begin
        if (!rst_n) begin
            mon_waits = 0;
        end else if (psel && penable) begin
            if (!pready) begin
                mon_waits++;
            end else begin
                if (apb_q.size() == 0) begin
                    check("unexpected APB completion", 32'd1, 32'd0);
                end else begin
                    mon_e = apb_q.pop_front();
                    if (mon_e.is_read) check({mon_e.name, " rdata"}, prdata, mon_e.rdata);
                    check({mon_e.name, " pslverr"}, {31'd0, pslverr}, {31'd0, mon_e.err});
                    check({mon_e.name, " wait states"}, mon_waits, mon_e.waits);
                end
                mon_waits = 0;
            end
        end
    end

    // PAN_PWM and FIRE_OUT pulse-length monitors
    int pan_len  = 0;
    int fire_len = 0;
    always @(negedge clk) begin
        if (!rst_n) begin
            pan_len  = 0;
            fire_len = 0;
        end else begin
            if (pan_pwm) begin
                pan_len++;
            end else if (pan_len > 0) begin
                if (pan_q.size() == 0) check("unexpected PAN pulse", pan_len, 0);
                else check("PAN pulse width", pan_len, pan_q.pop_front());
                $display("pan pulse width %0d", pan_len);
                pan_len = 0;
            end
            if (fire_out) begin
                fire_len++;
            end else if (fire_len > 0) begin
                if (fire_q.size() == 0) check("unexpected FIRE pulse", fire_len, 0);
                else check("FIRE pulse length", fire_len, fire_q.pop_front());
                $display("fire pulse length %0d", fire_len);
                fire_len = 0;
            end
        end
    end

    initial begin
        rst_n = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = 8'h00; pwdata = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        check("reset PRDATA", prdata, 32'd0);
        check("reset PREADY", {31'd0, pready}, 32'd1);
        check("reset PSLVERR", {31'd0, pslverr}, 32'd0);
        check("reset PAN_PWM", {31'd0, pan_pwm}, 32'd0);
        check("reset TILT_PWM", {31'd0, tilt_pwm}, 32'd0);
        check("reset FIRE_OUT", {31'd0, fire_out}, 32'd0);
        rst_n = 1'b1;

        // Reset values and clamping
        apb("rd PAN reset",  1'b0, 8'h04, 0, 75, 1'b0);
        apb("rd TILT reset", 1'b0, 8'h08, 0, 75, 1'b0);
        apb("rd CTRL reset", 1'b0, 8'h00, 0, 0,  1'b0);
        apb("wr PAN 10",     1'b1, 8'h04, 10, 0, 1'b0);
        apb("rd PAN min",    1'b0, 8'h04, 0, 50, 1'b0);
        apb("wr PAN 500",    1'b1, 8'h04, 500, 0, 1'b0);
        apb("rd PAN max",    1'b0, 8'h04, 0, 100, 1'b0);
        apb("wr TILT 60",    1'b1, 8'h08, 60, 0, 1'b0);
        apb("rd TILT 60",    1'b0, 8'h08, 0, 60, 1'b0);

        // PWM: the first frame keeps 80 despite a mid-frame write; the next frame uses 60
        apb("wr PAN 80",     1'b1, 8'h04, 80, 0, 1'b0);
        pan_q.push_back(80);
        pan_q.push_back(60);
        apb("wr CTRL EN",    1'b1, 8'h00, 1, 0, 1'b0);
        repeat (25) @(posedge clk);
        apb("wr PAN 60 mid-frame", 1'b1, 8'h04, 60, 0, 1'b0);
        for (int i = 0; i < 3000 && pan_q.size() != 0; i++) @(posedge clk);
        check("PAN pulses seen", pan_q.size(), 0);
        apb("rd STATUS flag", 1'b0, 8'h0C, 0, 32'h2, 1'b0);
        apb("w1c FRAME_FLAG", 1'b1, 8'h0C, 32'h2, 0, 1'b0);
        apb("rd STATUS clr",  1'b0, 8'h0C, 0, 32'h0, 1'b0);
        apb("wr CTRL dis",    1'b1, 8'h00, 0, 0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("PAN_PWM after disable", {31'd0, pan_pwm}, 32'd0);

        // Fire: the retrigger while busy must not extend the pulse
        fire_q.push_back(20);
        apb("wr CTRL FIRE",       1'b1, 8'h00, 32'h2, 0, 1'b0);
        repeat (8) @(posedge clk);
        apb("wr CTRL FIRE busy",  1'b1, 8'h00, 32'h2, 0, 1'b0);
        apb("rd STATUS busy",     1'b0, 8'h0C, 0, 32'h1, 1'b0);
        for (int i = 0; i < 100 && fire_q.size() != 0; i++) @(posedge clk);
        check("FIRE pulse seen", fire_q.size(), 0);
        apb("rd STATUS idle",     1'b0, 8'h0C, 0, 32'h0, 1'b0);

        // Unmapped accesses
        apb("wr 0x10",  1'b1, 8'h10, 32'hFFFF_FFFF, 0, 1'b1);
        apb("rd 0x10",  1'b0, 8'h10, 0, 0, 1'b1);
        apb("rd 0xFC",  1'b0, 8'hFC, 0, 0, 1'b1);
        apb("rd CTRL",  1'b0, 8'h00, 0, 0, 1'b0);
        apb("rd TILT",  1'b0, 8'h08, 0, 60, 1'b0);
        apb("rd STATUS",1'b0, 8'h0C, 0, 0, 1'b0);
        apb("rd PAN",   1'b0, 8'h04, 0, 60, 1'b0);

        // Reset during a read wait state and during a fire pulse
        apb("wr CTRL FIRE pre-reset", 1'b1, 8'h00, 32'h2, 0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 8'h04;
        @(posedge clk); #1;
        penable = 1'b1;
        @(negedge clk);
        check("PREADY low in read wait", {31'd0, pready}, 32'd0);
        check("FIRE_OUT high before reset", {31'd0, fire_out}, 32'd1);
        #1;
        rst_n = 1'b0; psel = 1'b0; penable = 1'b0;
        #1;
        check("async reset PREADY", {31'd0, pready}, 32'd1);
        check("async reset PRDATA", prdata, 32'd0);
        check("async reset PSLVERR", {31'd0, pslverr}, 32'd0);
        check("async reset FIRE_OUT", {31'd0, fire_out}, 32'd0);
        check("async reset PAN_PWM", {31'd0, pan_pwm}, 32'd0);
        check("async reset TILT_PWM", {31'd0, tilt_pwm}, 32'd0);
        $display("reset asserted mid-read and mid-fire");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        apb("rd PAN after reset",    1'b0, 8'h04, 0, 75, 1'b0);
        apb("rd TILT after reset",   1'b0, 8'h08, 0, 75, 1'b0);
        apb("rd CTRL after reset",   1'b0, 8'h00, 0, 0, 1'b0);
        apb("rd STATUS after reset", 1'b0, 8'h0C, 0, 0, 1'b0);

        repeat (3) @(posedge clk);
        check("APB scoreboard drained", apb_q.size(), 0);
        check("FIRE scoreboard drained", fire_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
